// File: rtl/blood_sprite_renderer.sv
// Hit-triggered 64x64 blood-splatter animation driver and colour-key compositor.
// Define BLOOD_FADE_EN to darken opaque pixels of the final animation frame.
module blood_sprite_renderer #(
    parameter int          N_FRAMES   = 8,
    parameter int          HOLD_TICKS = 4,
    parameter logic [11:0] KEY_COLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic [11:0] bg_rgb,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    output logic [2:0]  rom_sel,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        busy
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [2:0]    FRAME_LAST = 3'(N_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

    state_t        state, state_nx;
    logic [2:0]    frame_idx, frame_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [9:0]    pos_x, pos_y, pos_x_nx, pos_y_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame_idx <= '0;
            hold_cnt  <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_idx <= frame_nx;
            hold_cnt  <= hold_nx;
            pos_x     <= pos_x_nx;
            pos_y     <= pos_y_nx;
            busy      <= (state_nx != IDLE);
        end
    end

    // A hit always wins over a coincident frame_tick.
    always_comb begin
        state_nx = state;
        frame_nx = frame_idx;
        hold_nx  = hold_cnt;
        pos_x_nx = pos_x;
        pos_y_nx = pos_y;
        if (hit) begin
            pos_x_nx = hit_x;
            pos_y_nx = hit_y;
            frame_nx = '0;
            hold_nx  = '0;
            state_nx = ARMED;
        end else if (frame_tick) begin
            case (state)
                ARMED: state_nx = PLAY;
                PLAY: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_nx = hold_cnt + 1'b1;
                    end else begin
                        hold_nx = '0;
                        if (frame_idx != FRAME_LAST) begin
                            frame_nx = frame_idx + 1'b1;
                        end else begin
                            frame_nx = '0;
                            state_nx = IDLE;
                        end
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    // 11-bit bounds so a sprite near the right/bottom edge clips instead of wrapping.
    logic [10:0] x_end, y_end;
    logic        in_sprite;

    assign x_end = {1'b0, pos_x} + 11'd64;
    assign y_end = {1'b0, pos_y} + 11'd64;

    assign in_sprite = (state == PLAY)
                    && (pixel_x >= pos_x) && ({1'b0, pixel_x} < x_end)
                    && (pixel_y >= pos_y) && ({1'b0, pixel_y} < y_end);

    assign rom_col = in_sprite ? (pixel_x[5:0] - pos_x[5:0]) : 6'd0;
    assign rom_row = in_sprite ? (pixel_y[5:0] - pos_y[5:0]) : 6'd0;
    assign rom_sel = frame_idx;

    logic        video_on_d1;
    logic        in_sprite_d1;
    logic [11:0] bg_d1;
    logic [11:0] sprite_rgb;

`ifdef BLOOD_FADE_EN
    logic fade_d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            fade_d1 <= 1'b0;
        end else begin
            fade_d1 <= (frame_idx == FRAME_LAST);
        end
    end

    assign sprite_rgb = fade_d1
        ? {1'b0, rom_data[11:9], 1'b0, rom_data[7:5], 1'b0, rom_data[3:1]}
        : rom_data;
`else
    assign sprite_rgb = rom_data;
`endif

    // Delay the pixel context one cycle to line up with the ROM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            video_on_d1  <= 1'b0;
            in_sprite_d1 <= 1'b0;
            bg_d1        <= '0;
            rgb_out      <= '0;
        end else begin
            video_on_d1  <= video_on;
            in_sprite_d1 <= in_sprite;
            bg_d1        <= bg_rgb;
            if (!video_on_d1) begin
                rgb_out <= '0;
            end else if (in_sprite_d1 && (rom_data != KEY_COLOR)) begin
                rgb_out <= sprite_rgb;
            end else begin
                rgb_out <= bg_d1;
            end
        end
    end

endmodule

// File: tb/tb_blood_sprite_renderer.sv
// Self-checking bench for blood_sprite_renderer against a tick-counting reference model.
// Build with +define+BLOOD_FADE_EN to check the faded final frame.
module tb_blood_sprite_renderer;

    localparam int          NF  = 8;
    localparam int          HT  = 4;
    localparam logic [11:0] KEY = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y, hit_x, hit_y;
    logic        video_on, frame_tick, hit;
    logic [11:0] bg_rgb, rom_data, rgb_out;
    logic [5:0]  rom_row, rom_col;
    logic [2:0]  rom_sel;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0=idle 1=armed 2=play; m_ticks counts ticks seen in play.
    int          m_mode, m_ticks, m_px, m_py;
    bit          m_von_d1, m_in_d1, m_last_d1;
    logic [11:0] m_bg_d1;
    bit          cur_in;
    int          cur_frame;
    int          exp_row, exp_col, exp_sel;
    int          prev_row, prev_col, prev_sel;
    logic [11:0] exp_rgb;
    bit          exp_busy;
    bit          rd_force;
    logic [11:0] rd_value;

    blood_sprite_renderer #(.N_FRAMES(NF), .HOLD_TICKS(HT), .KEY_COLOR(KEY)) dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .bg_rgb(bg_rgb),
        .frame_tick(frame_tick), .hit(hit),
        .hit_x(hit_x), .hit_y(hit_y),
        .rom_row(rom_row), .rom_col(rom_col), .rom_sel(rom_sel),
        .rom_data(rom_data), .rgb_out(rgb_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] rom_fn(int r, int c, int s);
        logic [11:0] v;
        v = 12'((r * 73 + c * 29 + s * 151 + 12'h5A3) & 12'hFFF);
        if ((r * 7 + c * 3 + s) % 6 == 0) v = 12'h000;
        return v;
    endfunction

    function automatic logic [11:0] shade(logic [11:0] c, bit last);
`ifdef BLOOD_FADE_EN
        return last ? ((c >> 1) & 12'h777) : c;
`else
        return c;
`endif
    endfunction

    task automatic drive(int px, int py, bit von, logic [11:0] bg,
                         bit tk, bit ht, int hx, int hy);
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        video_on   = von;
        bg_rgb     = bg;
        frame_tick = tk;
        hit        = ht;
        hit_x      = 10'(hx);
        hit_y      = 10'(hy);
        cur_frame  = m_ticks / HT;
        cur_in = (m_mode == 2) && px >= m_px && px < m_px + 64
              && py >= m_py && py < m_py + 64;
        exp_col = cur_in ? px - m_px : 0;
        exp_row = cur_in ? py - m_py : 0;
        exp_sel = cur_frame;
        rom_data = rd_force ? rd_value : rom_fn(prev_row, prev_col, prev_sel);
        #1;
    endtask

    task automatic clock_edge();
        if (reset) begin
            m_mode = 0; m_ticks = 0; m_px = 0; m_py = 0;
            m_von_d1 = 0; m_in_d1 = 0; m_last_d1 = 0; m_bg_d1 = 0;
            exp_rgb = 0;
        end else begin
            if (!m_von_d1) exp_rgb = 0;
            else if (m_in_d1 && rom_data !== KEY) exp_rgb = shade(rom_data, m_last_d1);
            else exp_rgb = m_bg_d1;
            m_von_d1 = video_on;
            m_bg_d1 = bg_rgb;
            m_in_d1 = cur_in;
            m_last_d1 = (cur_frame == NF - 1);
            if (hit) begin
                m_mode = 1; m_ticks = 0; m_px = int'(hit_x); m_py = int'(hit_y);
            end else if (frame_tick) begin
                if (m_mode == 1) m_mode = 2;
                else if (m_mode == 2) begin
                    m_ticks++;
                    if (m_ticks == NF * HT) begin m_mode = 0; m_ticks = 0; end
                end
            end
        end
        exp_busy = (m_mode != 0);
        prev_row = exp_row; prev_col = exp_col; prev_sel = exp_sel;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic advance_ticks(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1, 12'h111, 1, 0, 0, 0);
            clock_edge();
            drive(0, 0, 1, 12'h111, 0, 0, 0, 0);
            clock_edge();
        end
    endtask

    task automatic test_reset();
        reset = 1; rd_force = 0;
        prev_row = 0; prev_col = 0; prev_sel = 0;
        m_mode = 0; m_ticks = 0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1,
                  12'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 5, 5);
            clock_edge();
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
            checks++;
            if (rgb_out !== 12'h000) begin failures++; $display("FAIL reset_rgb got %h exp 000", rgb_out); end
        end
        reset = 0;
        drive(10, 10, 1, 12'h0F0, 0, 0, 0, 0);
        checks++;
        if (rom_row !== 6'd0 || rom_col !== 6'd0 || rom_sel !== 3'd0) begin
            failures++;
            $display("FAIL idle_addr got %0d/%0d/%0d exp 0/0/0", rom_row, rom_col, rom_sel);
        end
        clock_edge();
        checks++;
        if (rgb_out !== 12'h000) begin failures++; $display("FAIL post_reset_rgb got %h exp 000", rgb_out); end
        drive(11, 10, 1, 12'h0F0, 0, 0, 0, 0);
        clock_edge();
        checks++;
        if (rgb_out !== 12'h0F0) begin failures++; $display("FAIL idle_bg got %h exp 0F0", rgb_out); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_alignment();
        drive(0, 0, 1, 12'h0F0, 1, 1, 100, 50);
        clock_edge();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL hit_busy got %b exp 1", busy); end
        drive(120, 60, 1, 12'h0F0, 0, 0, 0, 0);
        checks++;
        if (rom_row !== 6'd0 || rom_col !== 6'd0) begin
            failures++; $display("FAIL armed_nodraw got %0d/%0d exp 0/0", rom_row, rom_col);
        end
        clock_edge();
        advance_ticks(1);
        drive(163, 113, 1, 12'h0F0, 0, 0, 0, 0);
        checks++;
        if (rom_col !== 6'd63 || rom_row !== 6'd63) begin
            failures++; $display("FAIL corner_addr got %0d/%0d exp 63/63", rom_col, rom_row);
        end
        clock_edge();
        rd_force = 1; rd_value = 12'hD00;
        drive(164, 113, 1, 12'h0F0, 0, 0, 0, 0);
        checks++;
        if (rom_col !== 6'd0 || rom_row !== 6'd0) begin
            failures++; $display("FAIL outside_addr got %0d/%0d exp 0/0", rom_col, rom_row);
        end
        clock_edge();
        checks++;
        if (rgb_out !== 12'hD00) begin failures++; $display("FAIL corner_rgb got %h exp D00", rgb_out); end
        rd_force = 0;
        drive(120, 60, 1, 12'h123, 0, 0, 0, 0);
        clock_edge();
        checks++;
        if (rgb_out !== 12'h0F0) begin failures++; $display("FAIL outside_rgb got %h exp 0F0", rgb_out); end
        rd_force = 1; rd_value = 12'h000;
        drive(121, 60, 1, 12'h000, 0, 0, 0, 0);
        clock_edge();
        rd_force = 0;
        checks++;
        if (rgb_out !== 12'h123) begin failures++; $display("FAIL key_rgb got %h exp 123", rgb_out); end
        checks++;
        if (rgb_out !== exp_rgb) begin failures++; $display("FAIL key_model got %h exp %h", rgb_out, exp_rgb); end
    endtask

    task automatic test_animation();
        drive(0, 0, 1, 12'h000, 0, 1, 100, 50);
        clock_edge();
        for (int t = 1; t <= 33; t++) begin
            drive(100 + $urandom_range(0, 70), 50 + $urandom_range(0, 70), 1,
                  12'($urandom), 1, 0, 0, 0);
            clock_edge();
            for (int g = 0; g < 2; g++) begin
                drive(95 + $urandom_range(0, 75), 45 + $urandom_range(0, 75), 1,
                      12'($urandom), 0, 0, 0, 0);
                checks++;
                if (rom_sel !== 3'((t <= 32) ? (t - 1) / 4 : 0)) begin
                    failures++; $display("FAIL anim_sel tick %0d got %0d exp %0d", t, rom_sel,
                                         (t <= 32) ? (t - 1) / 4 : 0);
                end
                checks++;
                if (rom_row !== 6'(exp_row) || rom_col !== 6'(exp_col)) begin
                    failures++; $display("FAIL anim_addr got %0d/%0d exp %0d/%0d",
                                         rom_row, rom_col, exp_row, exp_col);
                end
                clock_edge();
                checks++;
                if (busy !== (t <= 32)) begin
                    failures++; $display("FAIL anim_busy tick %0d got %b exp %b", t, busy, t <= 32);
                end
                checks++;
                if (rgb_out !== exp_rgb) begin
                    failures++; $display("FAIL anim_rgb got %h exp %h", rgb_out, exp_rgb);
                end
            end
        end
    endtask

    task automatic test_edge_clip();
        drive(0, 0, 1, 12'h000, 0, 1, 1000, 200);
        clock_edge();
        advance_ticks(1);
        for (int px = 990; px < 1032; px++) begin
            int x;
            int want;
            x = (px < 1024) ? px : px - 1024;
            want = (x >= 1000) ? x - 1000 : 0;
            drive(x, 210, 1, 12'($urandom), 0, 0, 0, 0);
            checks++;
            if (rom_col !== 6'(want) || rom_row !== 6'(x >= 1000 ? 10 : 0)) begin
                failures++; $display("FAIL clip_addr x %0d got %0d/%0d exp %0d", x, rom_col, rom_row, want);
            end
            clock_edge();
            checks++;
            if (rgb_out !== exp_rgb) begin failures++; $display("FAIL clip_rgb got %h exp %h", rgb_out, exp_rgb); end
        end
    endtask

    task automatic test_restart();
        drive(0, 0, 1, 12'h000, 0, 1, 300, 100);
        clock_edge();
        advance_ticks(21);
        drive(310, 110, 1, 12'h000, 0, 0, 0, 0);
        checks++;
        if (rom_sel !== 3'd5) begin failures++; $display("FAIL restart_pre_sel got %0d exp 5", rom_sel); end
        drive(310, 110, 1, 12'h000, 1, 1, 40, 400);
        clock_edge();
        drive(45, 410, 1, 12'h000, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || rom_sel !== 3'd0) begin
            failures++; $display("FAIL restart_state got busy %b sel %0d exp 1/0", busy, rom_sel);
        end
        checks++;
        if (rom_row !== 6'd0 || rom_col !== 6'd0) begin
            failures++; $display("FAIL restart_armed got %0d/%0d exp 0/0", rom_row, rom_col);
        end
        clock_edge();
        advance_ticks(1);
        drive(45, 410, 1, 12'h000, 0, 0, 0, 0);
        checks++;
        if (rom_col !== 6'd5 || rom_row !== 6'd10) begin
            failures++; $display("FAIL restart_pos got %0d/%0d exp 5/10", rom_col, rom_row);
        end
        clock_edge();
    endtask

    task automatic test_last_frame();
        drive(0, 0, 1, 12'h000, 0, 1, 10, 10);
        clock_edge();
        advance_ticks(1 + 28);
        drive(12, 12, 1, 12'h0F0, 0, 0, 0, 0);
        checks++;
        if (rom_sel !== 3'd7) begin failures++; $display("FAIL last_sel got %0d exp 7", rom_sel); end
        clock_edge();
        rd_force = 1; rd_value = 12'hD84;
        drive(13, 12, 1, 12'h0F0, 0, 0, 0, 0);
        clock_edge();
        rd_force = 0;
        checks++;
`ifdef BLOOD_FADE_EN
        if (rgb_out !== 12'h642) begin failures++; $display("FAIL fade_rgb got %h exp 642", rgb_out); end
`else
        if (rgb_out !== 12'hD84) begin failures++; $display("FAIL last_rgb got %h exp D84", rgb_out); end
`endif
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1, 12'h000, 0, 1, 200, 200);
        clock_edge();
        advance_ticks(6);
        reset = 1;
        drive(210, 210, 1, 12'hABC, 0, 0, 0, 0);
        clock_edge();
        reset = 0;
        checks++;
        if (busy !== 1'b0 || rgb_out !== 12'h000) begin
            failures++; $display("FAIL midreset got busy %b rgb %h exp 0/000", busy, rgb_out);
        end
        drive(210, 210, 1, 12'h456, 0, 0, 0, 0);
        clock_edge();
        checks++;
        if (rgb_out !== 12'h000) begin failures++; $display("FAIL midreset_first got %h exp 000", rgb_out); end
        drive(211, 210, 1, 12'h789, 0, 0, 0, 0);
        clock_edge();
        checks++;
        if (rgb_out !== 12'h456) begin failures++; $display("FAIL midreset_bg got %h exp 456", rgb_out); end
    endtask

    task automatic test_random_traffic(int n);
        for (int i = 0; i < n; i++) begin
            int px, py;
            bit ht;
            if ($urandom_range(0, 1) == 1) begin
                px = m_px + $urandom_range(0, 70) - 3;
                py = m_py + $urandom_range(0, 70) - 3;
            end else begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            px = (px < 0) ? 0 : (px > 1023 ? 1023 : px);
            py = (py < 0) ? 0 : (py > 1023 ? 1023 : py);
            ht = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 999) == 0);
            drive(px, py, ($urandom_range(0, 7) != 0), 12'($urandom),
                  ($urandom_range(0, 9) == 0), ht,
                  $urandom_range(0, 1023), $urandom_range(0, 1023));
            checks++;
            if (rom_row !== 6'(exp_row) || rom_col !== 6'(exp_col) || rom_sel !== 3'(exp_sel)) begin
                failures++; $display("FAIL rand_addr got %0d/%0d/%0d exp %0d/%0d/%0d",
                                     rom_row, rom_col, rom_sel, exp_row, exp_col, exp_sel);
            end
            clock_edge();
            checks++;
            if (rgb_out !== exp_rgb || busy !== exp_busy) begin
                failures++; $display("FAIL rand_out got %h/%b exp %h/%b", rgb_out, busy, exp_rgb, exp_busy);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        rd_force = 0;
        rd_value = 0;
        drive(0, 0, 0, 12'h000, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_alignment();
        test_animation();
        test_edge_clip();
        test_restart();
        test_last_frame();
        test_reset_mid();
        test_random_traffic(5000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blood_sprite_renderer.md
# blood_sprite_renderer

Upstream driver and downstream compositor for the 64x64 blood-splatter sprite ROMs. On a hit event it latches a screen position and plays an N-frame splatter animation paced by vertical frame ticks. It generates the ROM row/column/frame-select address from the VGA pixel coordinates, re-aligns the ROM's one-cycle-late colour with the background pixel, applies colour-key transparency, and outputs the composited RGB to the VGA output stage.

## Interface
- N_FRAMES, 8: animation frames (ROM instances), 1..8
- HOLD_TICKS, 4: frame_tick pulses each animation frame stays on screen, >=1
- KEY_COLOR, 12'h000: transparent sprite colour
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- video_on  in  1  visible-area flag, aligned with pixel_x/pixel_y
- bg_rgb  in  12  background colour, aligned with pixel_x/pixel_y
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- hit  in  1  one-cycle request to start/restart the animation
- hit_x, hit_y  in  10 each  sprite top-left for this hit
- rom_row, rom_col  out  6 each  sprite ROM address (combinational)
- rom_sel  out  3  ROM instance (animation frame) select (combinational)
- rom_data  in  12  colour from the selected ROM, one cycle after its address
- rgb_out  out  12  composited pixel (registered)
- busy  out  1  high in ARMED or PLAY (registered)

## Operation
- States: IDLE, ARMED, PLAY. Reset: IDLE, frame_idx=0, hold_cnt=0, pos_x=pos_y=0, rgb_out=0, busy=0.
- IDLE + hit: latch hit_x/hit_y into pos_x/pos_y, frame_idx=0, hold_cnt=0 -> ARMED. frame_tick in the same cycle as hit is ignored.
- ARMED + frame_tick -> PLAY. The sprite is never drawn in ARMED, so it always starts at a frame boundary.
- PLAY + frame_tick:
  - If hold_cnt<HOLD_TICKS-1: hold_cnt++.
  - Otherwise hold_cnt=0 and:
    - if frame_idx<N_FRAMES-1: frame_idx++;
    - else -> IDLE, frame_idx=0.
- hit in ARMED or PLAY: relatch position, frame_idx=0, hold_cnt=0 -> ARMED. This restart takes priority over a simultaneous frame_tick.
- in_sprite = (state==PLAY) && pixel_x>=pos_x && pixel_x<pos_x+64 && pixel_y>=pos_y && pixel_y<pos_y+64.
  - Sums are computed at 11 bits, so sprites clip at the screen edge and never wrap.
- When in_sprite:
  - rom_col=(pixel_x-pos_x)[5:0];
  - rom_row=(pixel_y-pos_y)[5:0].
- Otherwise rom_row=rom_col=0.
- rom_sel=frame_idx in all states.
- Composite stage (d1 = values delayed one cycle):
  - video_on_d1=0 -> rgb_out=0;
  - else in_sprite_d1 && rom_data!=KEY_COLOR -> rgb_out=rom_data;
  - else rgb_out=bg_rgb_d1.
- Every pipeline register clears on reset.

## Timing
- Pixel presented at cycle N: address out at N, ROM data at N+1, rgb_out at N+2. Fixed latency 2 for every pixel, sprite or not.
- video_on, bg_rgb and in_sprite each get exactly one delay register before the output register.
- State, frame_idx and pos change only on the clock edge of hit/frame_tick.
- Reset asserted mid-animation: next edge goes to IDLE, busy=0, rgb_out=0. The first post-reset rgb_out reflects a pixel sampled after reset deasserts.
- busy rises the cycle after hit. It falls the cycle after the final frame_tick of the last frame.

## Configuration
- BLOOD_FADE_EN defined: while frame_idx==N_FRAMES-1, opaque sprite pixels output each 4-bit channel shifted right by 1 (e.g. 12'hD00 -> 12'h600). Key comparison uses the unshifted rom_data.
- BLOOD_FADE_EN undefined: sprite colour passes through unmodified in all frames.

## Test plan
- Reset, then no hit: bg_rgb=12'h0F0, video_on=1 -> rgb_out=12'h0F0 two cycles later; busy=0, rom_row=rom_col=0.
- hit at (100,50), N_FRAMES=8, HOLD_TICKS=4 -> busy=1, nothing drawn until the first frame_tick. rom_sel steps 0..7 every 4 ticks. IDLE/busy=0 follows the 33rd tick (1 arming tick + 32 play ticks).
- Alignment in PLAY:
  - pixel (163,113) -> rom_col=63, rom_row=63; rom_data=12'hD00 -> rgb_out=12'hD00 at N+2.
  - pixel (164,113) -> background.
  - rom_data=12'h000 inside the sprite -> background.
- hit_x=1000 -> pixels 1000..1023 map to rom_col 0..23; no wrap to column 0 of the screen.
- hit during PLAY at frame 5 simultaneous with frame_tick -> ARMED, rom_sel=0, new position.
  - Reset asserted during PLAY -> IDLE, rgb_out=0 next cycle.
- BLOOD_FADE_EN build: last frame rom_data=12'hD84 -> rgb_out=12'h642; earlier frames unmodified.
